// File: rtl/rdma_ctrl_sink_pkg.sv
// Shared types and widths for the RDMA control-path sink.
// Optional statistics are enabled with the RDMA_CTRL_SINK_STATS_EN macro (see rdma_ctrl_sink.sv).
package rdma_ctrl_sink_pkg;

  localparam int RDMA_QPN_BITS       = 24;
  localparam int RDMA_QP_INTF_BITS   = 96;
  localparam int RDMA_QP_CONN_BITS   = 128;
  localparam int RDMA_CTRL_DATA_BITS = (RDMA_QP_INTF_BITS > RDMA_QP_CONN_BITS) ?
                                       RDMA_QP_INTF_BITS : RDMA_QP_CONN_BITS;
  localparam int RDMA_CTRL_ACK_BITS  = 1 + 2 + RDMA_QPN_BITS;

  typedef enum logic [1:0] {
    RDMA_CTRL_OK        = 2'd0,
    RDMA_CTRL_ERR_RANGE = 2'd1,
    RDMA_CTRL_ERR_NOQP  = 2'd2
  } rdma_ctrl_err_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } rdma_ctrl_state_t;

  // Completion word layout: {type, err, qpn}
  function automatic logic [RDMA_CTRL_ACK_BITS-1:0] rdma_ctrl_pack_ack(
    input logic                     i_type,
    input rdma_ctrl_err_t           i_err,
    input logic [RDMA_QPN_BITS-1:0] i_qpn
  );
    return {i_type, i_err, i_qpn};
  endfunction

endpackage

// File: rtl/rdma_ctrl_rr_arb.sv
// Two-input round-robin grant between the QP-context and connection streams.
// The pointer names the side that wins a tie; it toggles after every accepted request.
module rdma_ctrl_rr_arb (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_reqQp,
  input  logic i_reqConn,
  input  logic i_advance,
  output logic o_gntQp,
  output logic o_gntConn
);

  logic r_ptrConn;

  // Grant a lone requester outright; on a tie the pointer side wins
  always_comb begin
    o_gntQp   = 1'b0;
    o_gntConn = 1'b0;
    if (i_reqQp && i_reqConn) begin
      o_gntQp   = ~r_ptrConn;
      o_gntConn = r_ptrConn;
    end else begin
      o_gntQp   = i_reqQp;
      o_gntConn = i_reqConn;
    end
  end

  // Pointer flips on each handshake and holds while idle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptrConn <= 1'b0;
    end else if (i_advance) begin
      r_ptrConn <= ~r_ptrConn;
    end
  end

endmodule

// File: rtl/rdma_ctrl_sink.sv
// Network-side terminator of the RDMA control path: arbitrates QP-context and
// connection requests, validates them, writes the context tables and acks each one.
// Define RDMA_CTRL_SINK_STATS_EN to add saturating per-category completion counters.
module rdma_ctrl_sink
  import rdma_ctrl_sink_pkg::*;
#(
  parameter int N_QP       = 16,
  parameter int STATS_BITS = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           s_qp_valid,
  output logic                           s_qp_ready,
  input  logic [RDMA_QP_INTF_BITS-1:0]   s_qp_data,
  input  logic                           s_conn_valid,
  output logic                           s_conn_ready,
  input  logic [RDMA_QP_CONN_BITS-1:0]   s_conn_data,
  output logic                           m_ctx_wr_valid,
  input  logic                           m_ctx_wr_ready,
  output logic                           m_ctx_wr_sel,
  output logic [RDMA_QPN_BITS-1:0]       m_ctx_wr_qpn,
  output logic [RDMA_CTRL_DATA_BITS-1:0] m_ctx_wr_data,
  output logic                           m_ack_valid,
  input  logic                           m_ack_ready,
  output logic [RDMA_CTRL_ACK_BITS-1:0]  m_ack_data
`ifdef RDMA_CTRL_SINK_STATS_EN
  ,
  output logic [STATS_BITS-1:0]          stat_qp_ok,
  output logic [STATS_BITS-1:0]          stat_conn_ok,
  output logic [STATS_BITS-1:0]          stat_err
`endif
);

  localparam int QIDX_BITS = (N_QP > 1) ? $clog2(N_QP) : 1;

  rdma_ctrl_state_t               r_state;
  rdma_ctrl_state_t               w_nextState;
  logic                           w_idle;
  logic                           w_gntQp;
  logic                           w_gntConn;
  logic                           w_inHs;
  logic                           w_wrHs;
  logic                           w_ackHs;

  logic                           w_capSel;
  logic [RDMA_QPN_BITS-1:0]       w_capQpn;
  logic [RDMA_CTRL_DATA_BITS-1:0] w_capData;
  rdma_ctrl_err_t                 w_capErr;

  logic                           r_sel;
  logic [RDMA_QPN_BITS-1:0]       r_qpn;
  logic [RDMA_CTRL_DATA_BITS-1:0] r_data;
  rdma_ctrl_err_t                 r_err;
  logic [N_QP-1:0]                r_qpValid;

  rdma_ctrl_rr_arb u_arb (
    .i_clk     (aclk),
    .i_reset   (areset),
    .i_reqQp   (s_qp_valid),
    .i_reqConn (s_conn_valid),
    .i_advance (w_inHs),
    .o_gntQp   (w_gntQp),
    .o_gntConn (w_gntConn)
  );

  assign s_qp_ready   = w_idle & w_gntQp;
  assign s_conn_ready = w_idle & w_gntConn;
  assign w_inHs  = (s_qp_valid & s_qp_ready) | (s_conn_valid & s_conn_ready);
  assign w_wrHs  = m_ctx_wr_valid & m_ctx_wr_ready;
  assign w_ackHs = m_ack_valid & m_ack_ready;

  assign w_capSel  = w_gntConn;
  assign w_capQpn  = w_gntConn ? s_conn_data[RDMA_QPN_BITS-1:0] : s_qp_data[RDMA_QPN_BITS-1:0];
  assign w_capData = w_gntConn ? RDMA_CTRL_DATA_BITS'(s_conn_data) : RDMA_CTRL_DATA_BITS'(s_qp_data);

  // Classify the granted request; an out-of-range QPN masks the bitmap lookup
  always_comb begin
    w_capErr = RDMA_CTRL_OK;
    if (w_capQpn >= RDMA_QPN_BITS'(N_QP)) begin
      w_capErr = RDMA_CTRL_ERR_RANGE;
    end else if (w_capSel && !r_qpValid[w_capQpn[QIDX_BITS-1:0]]) begin
      w_capErr = RDMA_CTRL_ERR_NOQP;
    end
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake outputs; rejected requests skip the table write
  always_comb begin
    w_nextState    = r_state;
    w_idle         = 1'b0;
    m_ctx_wr_valid = 1'b0;
    m_ack_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (w_inHs) begin
          w_nextState = (w_capErr == RDMA_CTRL_OK) ? ST_WRITE : ST_ACK;
        end
      end
      ST_WRITE: begin
        m_ctx_wr_valid = 1'b1;
        if (m_ctx_wr_ready) begin
          w_nextState = ST_ACK;
        end
      end
      ST_ACK: begin
        m_ack_valid = 1'b1;
        if (m_ack_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Hold the accepted request so write and ack data stay stable under backpressure
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_sel  <= 1'b0;
      r_qpn  <= '0;
      r_data <= '0;
      r_err  <= RDMA_CTRL_OK;
    end else if (w_inHs) begin
      r_sel  <= w_capSel;
      r_qpn  <= w_capQpn;
      r_data <= w_capData;
      r_err  <= w_capErr;
    end
  end

  // A QP becomes valid once its context write is accepted by the table
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_qpValid <= '0;
    end else if (w_wrHs && !r_sel) begin
      r_qpValid[r_qpn[QIDX_BITS-1:0]] <= 1'b1;
    end
  end

  assign m_ctx_wr_sel  = r_sel;
  assign m_ctx_wr_qpn  = r_qpn;
  assign m_ctx_wr_data = r_data;
  assign m_ack_data    = rdma_ctrl_pack_ack(r_sel, r_err, r_qpn);

`ifdef RDMA_CTRL_SINK_STATS_EN
  logic [STATS_BITS-1:0] r_statQpOk;
  logic [STATS_BITS-1:0] r_statConnOk;
  logic [STATS_BITS-1:0] r_statErr;

  // Saturating completion counters, bumped when the ack is taken
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_statQpOk   <= '0;
      r_statConnOk <= '0;
      r_statErr    <= '0;
    end else if (w_ackHs) begin
      if (r_err != RDMA_CTRL_OK) begin
        if (r_statErr != '1) r_statErr <= r_statErr + STATS_BITS'(1);
      end else if (r_sel) begin
        if (r_statConnOk != '1) r_statConnOk <= r_statConnOk + STATS_BITS'(1);
      end else begin
        if (r_statQpOk != '1) r_statQpOk <= r_statQpOk + STATS_BITS'(1);
      end
    end
  end

  assign stat_qp_ok   = r_statQpOk;
  assign stat_conn_ok = r_statConnOk;
  assign stat_err     = r_statErr;
`else
  logic w_ackHsUnused;
  assign w_ackHsUnused = w_ackHs;
`endif

endmodule

// File: tb/tb_rdma_ctrl_sink.sv
// Directed self-checking bench for rdma_ctrl_sink (N_QP=16).
// Stat outputs are connected and checked when RDMA_CTRL_SINK_STATS_EN is defined.
module tb_rdma_ctrl_sink;
  import rdma_ctrl_sink_pkg::*;

  logic                           aclk = 1'b0;
  logic                           areset;
  logic                           s_qp_valid;
  logic                           s_qp_ready;
  logic [RDMA_QP_INTF_BITS-1:0]   s_qp_data;
  logic                           s_conn_valid;
  logic                           s_conn_ready;
  logic [RDMA_QP_CONN_BITS-1:0]   s_conn_data;
  logic                           m_ctx_wr_valid;
  logic                           m_ctx_wr_ready;
  logic                           m_ctx_wr_sel;
  logic [RDMA_QPN_BITS-1:0]       m_ctx_wr_qpn;
  logic [RDMA_CTRL_DATA_BITS-1:0] m_ctx_wr_data;
  logic                           m_ack_valid;
  logic                           m_ack_ready;
  logic [RDMA_CTRL_ACK_BITS-1:0]  m_ack_data;
`ifdef RDMA_CTRL_SINK_STATS_EN
  logic [31:0] stat_qp_ok;
  logic [31:0] stat_conn_ok;
  logic [31:0] stat_err;
`endif

  int nChecks = 0;
  int nFails  = 0;

  rdma_ctrl_sink #(.N_QP(16), .STATS_BITS(32)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_qp_valid     (s_qp_valid),
    .s_qp_ready     (s_qp_ready),
    .s_qp_data      (s_qp_data),
    .s_conn_valid   (s_conn_valid),
    .s_conn_ready   (s_conn_ready),
    .s_conn_data    (s_conn_data),
    .m_ctx_wr_valid (m_ctx_wr_valid),
    .m_ctx_wr_ready (m_ctx_wr_ready),
    .m_ctx_wr_sel   (m_ctx_wr_sel),
    .m_ctx_wr_qpn   (m_ctx_wr_qpn),
    .m_ctx_wr_data  (m_ctx_wr_data),
    .m_ack_valid    (m_ack_valid),
    .m_ack_ready    (m_ack_ready),
    .m_ack_data     (m_ack_data)
`ifdef RDMA_CTRL_SINK_STATS_EN
    ,
    .stat_qp_ok     (stat_qp_ok),
    .stat_conn_ok   (stat_conn_ok),
    .stat_err       (stat_err)
`endif
  );

  // Free-running clock
  initial forever #5 aclk = ~aclk;

  // Watchdog so a broken design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset         = 1'b1;
    s_qp_valid     = 1'b0;
    s_conn_valid   = 1'b0;
    s_qp_data      = '0;
    s_conn_data    = '0;
    m_ctx_wr_ready = 1'b1;
    m_ack_ready    = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  function automatic logic [RDMA_QP_INTF_BITS-1:0] mkQp(input logic [23:0] qpn,
                                                         input logic [71:0] pl);
    return {pl, qpn};
  endfunction

  function automatic logic [RDMA_QP_CONN_BITS-1:0] mkConn(input logic [23:0] qpn,
                                                           input logic [103:0] pl);
    return {pl, qpn};
  endfunction

  task automatic test_reset();
    do_reset();
    nChecks++;
    if ({s_qp_ready, s_conn_ready, m_ctx_wr_valid, m_ack_valid} !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reset_handshakes: got %b expected 0000",
               {s_qp_ready, s_conn_ready, m_ctx_wr_valid, m_ack_valid});
    end
    nChecks++;
    if ({m_ctx_wr_sel, m_ctx_wr_qpn, m_ctx_wr_data, m_ack_data} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_data: got wr_data=%h ack=%h expected zeros", m_ctx_wr_data, m_ack_data);
    end
`ifdef RDMA_CTRL_SINK_STATS_EN
    nChecks++;
    if ({stat_qp_ok, stat_conn_ok, stat_err} !== 96'd0) begin
      nFails++;
      $display("[TB] FAIL reset_stats: got %h expected 0", {stat_qp_ok, stat_conn_ok, stat_err});
    end
`endif
  endtask

  task automatic test_qp_then_conn();
    logic [RDMA_CTRL_DATA_BITS-1:0] expData;
    do_reset();
    s_qp_data  = mkQp(24'd3, 72'hA5_0102_0304_0506_0708);
    s_qp_valid = 1'b1;
    #1;
    nChecks++;
    if ({s_qp_ready, s_conn_ready} !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL qc_qp_grant: got %b expected 10", {s_qp_ready, s_conn_ready});
    end
    step();
    s_qp_valid = 1'b0;
    expData = '0;
    expData[RDMA_QP_INTF_BITS-1:0] = mkQp(24'd3, 72'hA5_0102_0304_0506_0708);
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid, m_ctx_wr_sel, m_ctx_wr_qpn} !== {3'b100, 24'd3}) begin
      nFails++;
      $display("[TB] FAIL qc_qp_write: got v=%b a=%b sel=%b qpn=%0d expected v=1 a=0 sel=0 qpn=3",
               m_ctx_wr_valid, m_ack_valid, m_ctx_wr_sel, m_ctx_wr_qpn);
    end
    nChecks++;
    if (m_ctx_wr_data !== expData) begin
      nFails++;
      $display("[TB] FAIL qc_qp_wrdata: got %h expected %h", m_ctx_wr_data, expData);
    end
    step();
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid, m_ack_data} !== {2'b01, 1'b0, 2'd0, 24'd3}) begin
      nFails++;
      $display("[TB] FAIL qc_qp_ack: got v=%b a=%b ack=%h expected v=0 a=1 ack=%h",
               m_ctx_wr_valid, m_ack_valid, m_ack_data, {1'b0, 2'd0, 24'd3});
    end
    step();
    s_conn_data  = mkConn(24'd3, 104'hC0FFEE_1122_3344_5566_7788_99);
    s_conn_valid = 1'b1;
    #1;
    nChecks++;
    if ({s_qp_ready, s_conn_ready, m_ack_valid} !== 3'b010) begin
      nFails++;
      $display("[TB] FAIL qc_conn_grant: got %b expected 010", {s_qp_ready, s_conn_ready, m_ack_valid});
    end
    step();
    s_conn_valid = 1'b0;
    expData = RDMA_CTRL_DATA_BITS'(mkConn(24'd3, 104'hC0FFEE_1122_3344_5566_7788_99));
    nChecks++;
    if ({m_ctx_wr_valid, m_ctx_wr_sel, m_ctx_wr_qpn, m_ctx_wr_data} !== {2'b11, 24'd3, expData}) begin
      nFails++;
      $display("[TB] FAIL qc_conn_write: got v=%b sel=%b qpn=%0d data=%h expected v=1 sel=1 qpn=3 data=%h",
               m_ctx_wr_valid, m_ctx_wr_sel, m_ctx_wr_qpn, m_ctx_wr_data, expData);
    end
    step();
    nChecks++;
    if ({m_ack_valid, m_ack_data} !== {1'b1, 1'b1, 2'd0, 24'd3}) begin
      nFails++;
      $display("[TB] FAIL qc_conn_ack: got a=%b ack=%h expected a=1 ack=%h",
               m_ack_valid, m_ack_data, {1'b1, 2'd0, 24'd3});
    end
    step();
`ifdef RDMA_CTRL_SINK_STATS_EN
    nChecks++;
    if ({stat_qp_ok, stat_conn_ok, stat_err} !== {32'd1, 32'd1, 32'd0}) begin
      nFails++;
      $display("[TB] FAIL qc_stats: got qp=%0d conn=%0d err=%0d expected 1 1 0",
               stat_qp_ok, stat_conn_ok, stat_err);
    end
`endif
  endtask

  task automatic test_conn_noqp();
    do_reset();
    s_conn_data  = mkConn(24'd5, 104'h55);
    s_conn_valid = 1'b1;
    step();
    s_conn_valid = 1'b0;
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid, m_ack_data} !== {2'b01, 1'b1, 2'd2, 24'd5}) begin
      nFails++;
      $display("[TB] FAIL noqp_ack: got v=%b a=%b ack=%h expected v=0 a=1 ack=%h",
               m_ctx_wr_valid, m_ack_valid, m_ack_data, {1'b1, 2'd2, 24'd5});
    end
    step();
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL noqp_idle: got %b expected 00", {m_ctx_wr_valid, m_ack_valid});
    end
  endtask

  task automatic test_range();
    do_reset();
    s_qp_data  = mkQp(24'd16, 72'h77);
    s_qp_valid = 1'b1;
    step();
    s_qp_valid = 1'b0;
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid, m_ack_data} !== {2'b01, 1'b0, 2'd1, 24'd16}) begin
      nFails++;
      $display("[TB] FAIL range_ack: got v=%b a=%b ack=%h expected v=0 a=1 ack=%h",
               m_ctx_wr_valid, m_ack_valid, m_ack_data, {1'b0, 2'd1, 24'd16});
    end
    step();
    s_conn_data  = mkConn(24'd0, 104'h1);
    s_conn_valid = 1'b1;
    step();
    s_conn_valid = 1'b0;
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid, m_ack_data} !== {2'b01, 1'b1, 2'd2, 24'd0}) begin
      nFails++;
      $display("[TB] FAIL range_bitmap: got v=%b a=%b ack=%h expected v=0 a=1 ack=%h",
               m_ctx_wr_valid, m_ack_valid, m_ack_data, {1'b1, 2'd2, 24'd0});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] expVec;
    logic       side;
    do_reset();
    s_qp_data    = mkQp(24'd1, 72'h11);
    s_conn_data  = mkConn(24'd1, 104'h22);
    s_qp_valid   = 1'b1;
    s_conn_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      side   = ((c / 3) % 2) == 1;
      expVec = 4'b0000;
      if (c % 3 == 0) expVec[3:2] = side ? 2'b01 : 2'b10;
      if (c % 3 == 1) expVec[1] = 1'b1;
      if (c % 3 == 2) expVec[0] = 1'b1;
      nChecks++;
      if ({s_qp_ready, s_conn_ready, m_ctx_wr_valid, m_ack_valid} !== expVec) begin
        nFails++;
        $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", c,
                 {s_qp_ready, s_conn_ready, m_ctx_wr_valid, m_ack_valid}, expVec);
      end
      if (c % 3 == 2) begin
        nChecks++;
        if (m_ack_data !== {side, 2'd0, 24'd1}) begin
          nFails++;
          $display("[TB] FAIL b2b_ack%0d: got %h expected %h", c / 3, m_ack_data, {side, 2'd0, 24'd1});
        end
      end
      step();
    end
    s_qp_valid   = 1'b0;
    s_conn_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [RDMA_CTRL_DATA_BITS-1:0] expData;
    do_reset();
    m_ctx_wr_ready = 1'b0;
    s_qp_data      = mkQp(24'd2, 72'hBEEF_CAFE);
    s_conn_data    = mkConn(24'd2, 104'hDEAD);
    s_qp_valid     = 1'b1;
    s_conn_valid   = 1'b1;
    #1;
    nChecks++;
    if ({s_qp_ready, s_conn_ready} !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL bp_grant: got %b expected 10", {s_qp_ready, s_conn_ready});
    end
    step();
    expData = RDMA_CTRL_DATA_BITS'(mkQp(24'd2, 72'hBEEF_CAFE));
    s_qp_data = mkQp(24'd9, 72'h0BAD);
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if ({s_qp_ready, s_conn_ready, m_ctx_wr_valid, m_ack_valid, m_ctx_wr_qpn, m_ctx_wr_data}
          !== {4'b0010, 24'd2, expData}) begin
        nFails++;
        $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b a=%b qpn=%0d data=%h expected rdy=00 v=1 a=0 qpn=2 data=%h",
                 i, {s_qp_ready, s_conn_ready}, m_ctx_wr_valid, m_ack_valid, m_ctx_wr_qpn,
                 m_ctx_wr_data, expData);
      end
      step();
    end
    m_ctx_wr_ready = 1'b1;
    step();
    nChecks++;
    if ({s_qp_ready, s_conn_ready, m_ctx_wr_valid, m_ack_valid, m_ack_data}
        !== {4'b0001, 1'b0, 2'd0, 24'd2}) begin
      nFails++;
      $display("[TB] FAIL bp_ack: got hs=%b ack=%h expected hs=0001 ack=%h",
               {s_qp_ready, s_conn_ready, m_ctx_wr_valid, m_ack_valid}, m_ack_data,
               {1'b0, 2'd0, 24'd2});
    end
    s_qp_valid   = 1'b0;
    s_conn_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_qp_data  = mkQp(24'd3, 72'h33);
    s_qp_valid = 1'b1;
    step();
    s_qp_valid = 1'b0;
    step();
    step();
    m_ctx_wr_ready = 1'b0;
    s_qp_valid     = 1'b1;
    step();
    s_qp_valid = 1'b0;
    nChecks++;
    if (m_ctx_wr_valid !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL rmid_inflight: got %b expected 1", m_ctx_wr_valid);
    end
    areset = 1'b1;
    step();
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL rmid_drop: got %b expected 00", {m_ctx_wr_valid, m_ack_valid});
    end
`ifdef RDMA_CTRL_SINK_STATS_EN
    nChecks++;
    if ({stat_qp_ok, stat_conn_ok, stat_err} !== 96'd0) begin
      nFails++;
      $display("[TB] FAIL rmid_stats: got qp=%0d conn=%0d err=%0d expected 0 0 0",
               stat_qp_ok, stat_conn_ok, stat_err);
    end
`endif
    areset         = 1'b0;
    m_ctx_wr_ready = 1'b1;
    step();
    s_conn_data  = mkConn(24'd3, 104'h3);
    s_conn_valid = 1'b1;
    step();
    s_conn_valid = 1'b0;
    nChecks++;
    if ({m_ctx_wr_valid, m_ack_valid, m_ack_data} !== {2'b01, 1'b1, 2'd2, 24'd3}) begin
      nFails++;
      $display("[TB] FAIL rmid_bitmap: got v=%b a=%b ack=%h expected v=0 a=1 ack=%h",
               m_ctx_wr_valid, m_ack_valid, m_ack_data, {1'b1, 2'd2, 24'd3});
    end
    step();
  endtask

  // Run every scenario in order, then report
  initial begin
    $display("[TB] starting rdma_ctrl_sink bench");
    test_reset();
    test_qp_then_conn();
    test_conn_noqp();
    test_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
